mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter for the single-port synchronous MEMORY. Shares it between the CPU fetch/execute path and a DMA/loader port (program load, debug peek/poke). The CPU has priority by default. A starvation counter and a bounded, lockable DMA burst guarantee forward progress for both requesters. The block sits between the CPU address/data bus and the MEMORY instance, and drives the CPU's ready (stall) input.

## Interface

Parameters:
- AW, 16, address width
- DW, 8, data width
- MAX_WAIT, 4, consecutive denied DMA cycles before DMA overrides the CPU (≥1)
- MAX_BURST, 8, maximum consecutive locked DMA beats (≥1)

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- R  in  1  reset, synchronous, active-high
- cpu_req  in  1  CPU access request this cycle
- cpu_we  in  1  CPU write enable
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_rdy  out  1  CPU access granted this cycle (combinational)
- cpu_rvalid  out  1  CPU read data valid (registered)
- cpu_rdata  out  DW  CPU read data
- dma_req  in  1  DMA access request
- dma_lock  in  1  hold the bus for a burst while dma_req stays high
- dma_we  in  1  DMA write enable
- dma_addr  in  AW  DMA address
- dma_wdata  in  DW  DMA write data
- dma_gnt  out  1  DMA access granted this cycle (combinational)
- dma_rvalid  out  1  DMA read data valid (registered)
- dma_rdata  out  DW  DMA read data
- mem_addr  out  AW  to MEMORY Address
- mem_we  out  1  to MEMORY WE
- mem_din  out  DW  to MEMORY DataIn
- mem_dout  in  DW  from MEMORY DataOut; one-cycle read latency

## Operation

- **Grant rule.** At most one grant per cycle. cpu_rdy and dma_gnt are never both 1.
- **Mux.** mem_addr, mem_we and mem_din come from the granted requester. With no grant: mem_addr = cpu_addr, mem_we = 0.
- **States.** Three states: ST_CPU, ST_DMA, ST_YIELD.
- **ST_CPU:**
  - dma_gnt = dma_req & (!cpu_req | wait_cnt == MAX_WAIT).
  - cpu_rdy = cpu_req & !dma_gnt.
  - A DMA grant with dma_lock = 1 moves to ST_DMA, burst_cnt = 1.
- **ST_DMA:**
  - dma_gnt = dma_req; cpu_rdy = cpu_req & !dma_req.
  - Each granted beat increments burst_cnt.
  - Go to ST_CPU if dma_req = 0 or dma_lock = 0.
  - Go to ST_YIELD when the granted beat is beat number MAX_BURST.
- **ST_YIELD:**
  - cpu_rdy = cpu_req; dma_gnt = dma_req & !cpu_req, single beat, lock ignored.
  - Always returns to ST_CPU.
- **wait_cnt** (saturating at MAX_WAIT):
  - increments on cycles where dma_req = 1 and dma_gnt = 0;
  - clears on dma_gnt or dma_req = 0.
- **burst_cnt:** clears whenever the arbiter is outside ST_DMA.
- **Read return:**
  - cpu_rvalid <= cpu_rdy & !cpu_we; dma_rvalid <= dma_gnt & !dma_we.
  - cpu_rdata = dma_rdata = mem_dout; meaningful only when the matching rvalid is 1.
- **Writes:** complete in the grant cycle. No rvalid is produced for a write.

## Timing

- **Reset** (R high at a rising edge):
  - state becomes ST_CPU; wait_cnt, burst_cnt, cpu_rvalid and dma_rvalid become 0.
  - While R is high: cpu_rdy = dma_gnt = 0, mem_we = 0, mem_addr = 0.
- **Reset mid-burst or mid-read:** the burst is abandoned. The pending rvalid is 0 in the cycle after reset.
- **Read latency:** grant in cycle N gives rvalid and data in cycle N+1. Back-to-back reads give one result per cycle.
- **Grants are combinational** on req and state. A requester must hold req, we, addr and wdata stable until it sees its grant.
- **Worst-case DMA latency** with the CPU requesting continuously: MAX_WAIT cycles of denial, then a grant in cycle MAX_WAIT+1 from the first request.
- **Worst-case CPU latency** while DMA is locked: MAX_BURST cycles. The CPU is then guaranteed the ST_YIELD cycle.
- **Simultaneous cpu_req and dma_req in ST_CPU** with wait_cnt < MAX_WAIT: the CPU wins and wait_cnt increments.
- **dma_lock dropping on a granted beat:** that beat completes, then the state moves to ST_CPU.

## Test plan

- **Reset:** hold R for 2 cycles with both reqs high → cpu_rdy = dma_gnt = mem_we = 0 and both rvalids 0. Release → cpu_rdy = 1 in the first cycle after release.
- **CPU read:** cpu_req = 1, cpu_addr = 0x0010, memory holds 0xA9 at 0x0010 → cpu_rdy = 1 in cycle N; cpu_rvalid = 1 and cpu_rdata = 0xA9 in N+1.
- **Starvation guard:**
  - Stimulus: MAX_WAIT = 4; cpu_req held high; dma_req raised at cycle 0 without lock.
  - Required: dma_gnt = 0 in cycles 0–3, dma_gnt = 1 in cycle 4, cpu_rdy = 0 in cycle 4, cpu_rdy = 1 in cycle 5.
- **Locked burst:**
  - Stimulus: MAX_BURST = 8; DMA writes 0x00..0x09 to 0x0200..0x0209 with lock held; cpu_req held high.
  - Required: 8 consecutive dma_gnt cycles, then one cpu_rdy (ST_YIELD), then DMA resumes only via the starvation rule.
  - Check: memory readback matches the written data.
- **Lock release:** DMA burst of 3 beats with lock dropped on beat 3 → state returns to ST_CPU and a pending cpu_req is granted the next cycle.
- **Reset mid-burst:** assert R during DMA beat 2 of a read burst → dma_rvalid = 0 in the following cycle, state ST_CPU, counters 0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the arbiter and the single-port memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_rdy;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          dma_req;
  logic          dma_lock;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt;
  logic          dma_rvalid;
  logic [DW-1:0] dma_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_lock, dma_we, dma_addr, dma_wdata,
    input  mem_dout,
    output cpu_rdy, cpu_rvalid, cpu_rdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_addr, mem_we, mem_din
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_lock, dma_we, dma_addr, dma_wdata,
    output mem_dout,
    input  cpu_rdy, cpu_rvalid, cpu_rdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_addr, mem_we, mem_din
  );
endinterface

// File: rtl/mem_arbiter.sv
// CPU/DMA arbiter for a single-port synchronous memory: CPU priority, DMA
// starvation override after MAX_WAIT denials, and lockable DMA bursts capped at MAX_BURST.
//
// state    | meaning
// ST_CPU   | default; CPU wins unless DMA has been denied MAX_WAIT times
// ST_DMA   | locked DMA burst in progress; DMA owns the bus while it requests
// ST_YIELD | burst hit MAX_BURST; CPU gets this cycle, then back to ST_CPU
module mem_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 8,
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input logic        CLK,
  input logic        R,
  mem_arbiter_if.slave bus
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [WW-1:0] WAIT_SAT   = WW'(MAX_WAIT);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  typedef enum logic [1:0] {ST_CPU, ST_DMA, ST_YIELD} state_t;

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic [BW-1:0] burst_cnt;
  logic          cpu_rdy;
  logic          dma_gnt;
  logic          cpu_rvalid;
  logic          dma_rvalid;

  always_comb begin
    cpu_rdy = 1'b0;
    dma_gnt = 1'b0;
    if (!R) begin
      case (state)
        ST_CPU: begin
          dma_gnt = bus.dma_req & (~bus.cpu_req | (wait_cnt == WAIT_SAT));
          cpu_rdy = bus.cpu_req & ~dma_gnt;
        end
        ST_DMA: begin
          dma_gnt = bus.dma_req;
          cpu_rdy = bus.cpu_req & ~bus.dma_req;
        end
        ST_YIELD: begin
          cpu_rdy = bus.cpu_req;
          dma_gnt = bus.dma_req & ~bus.cpu_req;
        end
        default: ;
      endcase
    end
  end

  assign bus.cpu_rdy    = cpu_rdy;
  assign bus.dma_gnt    = dma_gnt;
  assign bus.cpu_rvalid = cpu_rvalid;
  assign bus.dma_rvalid = dma_rvalid;
  assign bus.cpu_rdata  = bus.mem_dout;
  assign bus.dma_rdata  = bus.mem_dout;
  assign bus.mem_addr   = R ? '0 : (dma_gnt ? bus.dma_addr : bus.cpu_addr);
  assign bus.mem_we     = (cpu_rdy & bus.cpu_we) | (dma_gnt & bus.dma_we);
  assign bus.mem_din    = dma_gnt ? bus.dma_wdata : bus.cpu_wdata;

  always_ff @(posedge CLK) begin
    if (R) begin
      state      <= ST_CPU;
      wait_cnt   <= '0;
      burst_cnt  <= '0;
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
    end else begin
      cpu_rvalid <= cpu_rdy & ~bus.cpu_we;
      dma_rvalid <= dma_gnt & ~bus.dma_we;

      if (dma_gnt || !bus.dma_req)
        wait_cnt <= '0;
      else if (wait_cnt != WAIT_SAT)
        wait_cnt <= wait_cnt + 1'b1;

      // burst_cnt counts beats already granted in the current burst
      burst_cnt <= '0;
      case (state)
        ST_CPU: begin
          if (dma_gnt && bus.dma_lock) begin
            if (MAX_BURST == 1) begin
              state <= ST_YIELD;
            end else begin
              state     <= ST_DMA;
              burst_cnt <= BW'(1);
            end
          end
        end
        ST_DMA: begin
          if (!bus.dma_req || !bus.dma_lock)
            state <= ST_CPU;
          else if (burst_cnt == BURST_LAST)
            state <= ST_YIELD;
          else
            burst_cnt <= burst_cnt + 1'b1;
        end
        ST_YIELD: state <= ST_CPU;
        default:  state <= ST_CPU;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run checked
// against a beat-counting reference model and a reference memory image.
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int MW = 4;
  localparam int MB = 8;

  logic clk = 1'b0;
  logic r   = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW), .MAX_BURST(MB)) dut (
    .CLK(clk),
    .R  (r),
    .bus(bus)
  );

  function automatic logic [7:0] pat(input logic [15:0] a);
    return (a == 16'h0010) ? 8'hA9 : (a[7:0] ^ a[15:8] ^ 8'h3C);
  endfunction

  // memory instance: one-cycle read latency
  logic [7:0] phys   [0:65535];
  bit         phys_v [0:65535];
  always @(posedge clk) begin
    if (bus.mem_we) begin
      phys[bus.mem_addr]   <= bus.mem_din;
      phys_v[bus.mem_addr] <= 1'b1;
    end
    bus.mem_dout <= phys_v[bus.mem_addr] ? phys[bus.mem_addr] : pat(bus.mem_addr);
  end

  // reference model: denials so far, beats used in a locked burst, owed yield cycle
  logic [7:0] ref_mem [0:65535];
  bit         ref_v   [0:65535];
  int   m_denied = 0;
  int   m_burst  = 0;
  bit   m_yield  = 0;
  bit   m_cpu_rv = 0, m_dma_rv = 0;
  logic [7:0]  m_cpu_rd = '0, m_dma_rd = '0;
  bit          e_cpu, e_dma, e_we;
  logic [15:0] e_addr;
  logic [7:0]  e_din;

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    return ref_v[a] ? ref_mem[a] : pat(a);
  endfunction

  task automatic model_eval();
    e_cpu = 0;
    e_dma = 0;
    if (!r) begin
      if (m_yield) begin
        e_cpu = bus.cpu_req;
        e_dma = bus.dma_req && !bus.cpu_req;
      end else if (m_burst > 0) begin
        e_dma = bus.dma_req;
        e_cpu = bus.cpu_req && !bus.dma_req;
      end else begin
        e_dma = bus.dma_req && (!bus.cpu_req || m_denied >= MW);
        e_cpu = bus.cpu_req && !e_dma;
      end
    end
    e_addr = r ? 16'h0 : (e_dma ? bus.dma_addr : bus.cpu_addr);
    e_we   = (e_cpu && bus.cpu_we) || (e_dma && bus.dma_we);
    e_din  = e_dma ? bus.dma_wdata : bus.cpu_wdata;
  endtask

  task automatic model_commit();
    if (r) begin
      m_denied = 0; m_burst = 0; m_yield = 0; m_cpu_rv = 0; m_dma_rv = 0;
    end else begin
      m_cpu_rv = e_cpu && !bus.cpu_we;
      m_dma_rv = e_dma && !bus.dma_we;
      if (m_cpu_rv) m_cpu_rd = ref_rd(bus.cpu_addr);
      if (m_dma_rv) m_dma_rd = ref_rd(bus.dma_addr);
      if (e_we) begin
        ref_mem[e_addr] = e_din;
        ref_v[e_addr]   = 1'b1;
      end
      if (bus.dma_req && !e_dma) m_denied = (m_denied + 1 > MW) ? MW : m_denied + 1;
      else m_denied = 0;
      if (m_yield) begin
        m_yield = 0;
      end else if (m_burst > 0) begin
        if (!bus.dma_req || !bus.dma_lock) m_burst = 0;
        else if (m_burst + 1 == MB) begin m_burst = 0; m_yield = 1; end
        else m_burst = m_burst + 1;
      end else if (e_dma && bus.dma_lock) begin
        if (MB == 1) m_yield = 1;
        else m_burst = 1;
      end
    end
  endtask

  task automatic drive(input logic cr, cw, input logic [15:0] ca, input logic [7:0] cd,
                       input logic dr, dl, dw, input logic [15:0] da, input logic [7:0] dd);
    bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
    bus.dma_req = dr; bus.dma_lock = dl; bus.dma_we = dw; bus.dma_addr = da; bus.dma_wdata = dd;
  endtask

  task automatic settle();
    #2;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 16'h0, 8'h0, 0, 0, 0, 16'h0, 8'h0);
    settle();
    tick();
  endtask

  task automatic test_reset();
    r = 1'b1;
    drive(1, 0, 16'h0010, 8'h0, 1, 1, 0, 16'h0200, 8'h0);
    for (int c = 0; c < 2; c++) begin
      settle();
      total++;
      if (bus.cpu_rdy !== 1'b0 || bus.dma_gnt !== 1'b0) begin
        bad++; $display("FAIL rst_grants cyc=%0d got cpu_rdy=%b dma_gnt=%b want 0 0", c, bus.cpu_rdy, bus.dma_gnt);
      end
      total++;
      if (bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0) begin
        bad++; $display("FAIL rst_mem cyc=%0d got we=%b addr=%h want 0 0000", c, bus.mem_we, bus.mem_addr);
      end
      if (c == 1) begin
        total++;
        if (bus.cpu_rvalid !== 1'b0 || bus.dma_rvalid !== 1'b0) begin
          bad++; $display("FAIL rst_rvalid got %b %b want 0 0", bus.cpu_rvalid, bus.dma_rvalid);
        end
      end
      tick();
    end
    r = 1'b0;
    drive(1, 0, 16'h0010, 8'h0, 1, 0, 0, 16'h0200, 8'h0);
    settle();
    total++;
    if (bus.cpu_rdy !== 1'b1 || bus.dma_gnt !== 1'b0) begin
      bad++; $display("FAIL rst_release got cpu_rdy=%b dma_gnt=%b want 1 0", bus.cpu_rdy, bus.dma_gnt);
    end
    tick();
  endtask

  task automatic test_cpu_read();
    drive(1, 0, 16'h0010, 8'h0, 0, 0, 0, 16'h0, 8'h0);
    settle();
    total++;
    if (bus.cpu_rdy !== 1'b1 || bus.mem_addr !== 16'h0010) begin
      bad++; $display("FAIL cpu_read_grant got rdy=%b addr=%h want 1 0010", bus.cpu_rdy, bus.mem_addr);
    end
    tick();
    drive(0, 0, 16'h0, 8'h0, 0, 0, 0, 16'h0, 8'h0);
    settle();
    total++;
    if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 8'hA9 || bus.dma_rvalid !== 1'b0) begin
      bad++; $display("FAIL cpu_read_data got rv=%b data=%h dma_rv=%b want 1 a9 0",
                      bus.cpu_rvalid, bus.cpu_rdata, bus.dma_rvalid);
    end
    tick();
  endtask

  task automatic test_starvation();
    idle();
    for (int c = 0; c <= 5; c++) begin
      drive(1, 0, 16'h0030, 8'h0, (c <= 4), 0, 1, 16'h0300, 8'h77);
      settle();
      total++;
      if (bus.dma_gnt !== (c == 4) || bus.cpu_rdy !== (c != 4)) begin
        bad++; $display("FAIL starve cyc=%0d got dma_gnt=%b cpu_rdy=%b want %b %b",
                        c, bus.dma_gnt, bus.cpu_rdy, (c == 4), (c != 4));
      end
      if (c == 4) begin
        total++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h0300 || bus.mem_din !== 8'h77) begin
          bad++; $display("FAIL starve_mux got we=%b addr=%h din=%h want 1 0300 77",
                          bus.mem_we, bus.mem_addr, bus.mem_din);
        end
      end
      tick();
    end
  endtask

  task automatic test_locked_burst();
    int  idx = 0;
    bit  exp_d;
    idle();
    for (int c = 0; c < 18; c++) begin
      drive(1, 0, 16'h0020, 8'h0, (idx < 10), 1, 1, 16'h0200 + 16'(idx), 8'(idx));
      settle();
      exp_d = (c >= 4 && c <= 11) || (c >= 16 && c <= 17);
      total++;
      if (bus.dma_gnt !== exp_d || bus.cpu_rdy !== !exp_d) begin
        bad++; $display("FAIL burst cyc=%0d got dma_gnt=%b cpu_rdy=%b want %b %b",
                        c, bus.dma_gnt, bus.cpu_rdy, exp_d, !exp_d);
      end
      if (bus.dma_gnt === 1'b1) idx++;
      tick();
    end
    idle();
    for (int i = 0; i <= 10; i++) begin
      drive(0, 0, 16'h0, 8'h0, (i < 10), 0, 0, 16'h0200 + 16'(i), 8'h0);
      settle();
      if (i > 0) begin
        total++;
        if (bus.dma_rvalid !== 1'b1 || bus.dma_rdata !== 8'(i - 1)) begin
          bad++; $display("FAIL burst_readback addr=%h got rv=%b data=%h want 1 %h",
                          16'h0200 + 16'(i - 1), bus.dma_rvalid, bus.dma_rdata, 8'(i - 1));
        end
      end
      tick();
    end
  endtask

  task automatic test_lock_release();
    idle();
    drive(0, 0, 16'h0040, 8'h0, 1, 1, 1, 16'h0210, 8'hB0);
    settle();
    total++;
    if (bus.dma_gnt !== 1'b1) begin bad++; $display("FAIL rel_beat1 got dma_gnt=%b want 1", bus.dma_gnt); end
    tick();
    drive(1, 0, 16'h0040, 8'h0, 1, 1, 1, 16'h0211, 8'hB1);
    settle();
    total++;
    if (bus.dma_gnt !== 1'b1 || bus.cpu_rdy !== 1'b0) begin
      bad++; $display("FAIL rel_beat2 got dma_gnt=%b cpu_rdy=%b want 1 0", bus.dma_gnt, bus.cpu_rdy);
    end
    tick();
    drive(1, 0, 16'h0040, 8'h0, 1, 0, 1, 16'h0212, 8'hB2);
    settle();
    total++;
    if (bus.dma_gnt !== 1'b1 || bus.cpu_rdy !== 1'b0) begin
      bad++; $display("FAIL rel_beat3 got dma_gnt=%b cpu_rdy=%b want 1 0", bus.dma_gnt, bus.cpu_rdy);
    end
    tick();
    drive(1, 0, 16'h0040, 8'h0, 1, 0, 1, 16'h0213, 8'hB3);
    settle();
    total++;
    if (bus.cpu_rdy !== 1'b1 || bus.dma_gnt !== 1'b0) begin
      bad++; $display("FAIL rel_cpu got cpu_rdy=%b dma_gnt=%b want 1 0", bus.cpu_rdy, bus.dma_gnt);
    end
    tick();
    idle();
  endtask

  task automatic test_reset_mid_burst();
    drive(0, 0, 16'h0, 8'h0, 1, 1, 0, 16'h0200, 8'h0);
    settle();
    total++;
    if (bus.dma_gnt !== 1'b1) begin bad++; $display("FAIL rmb_beat1 got dma_gnt=%b want 1", bus.dma_gnt); end
    tick();
    r = 1'b1;
    drive(0, 0, 16'h0, 8'h0, 1, 1, 0, 16'h0201, 8'h0);
    settle();
    total++;
    if (bus.dma_gnt !== 1'b0 || bus.dma_rvalid !== 1'b1 || bus.dma_rdata !== 8'h00) begin
      bad++; $display("FAIL rmb_in_reset got gnt=%b rv=%b data=%h want 0 1 00",
                      bus.dma_gnt, bus.dma_rvalid, bus.dma_rdata);
    end
    tick();
    r = 1'b0;
    for (int c = 0; c <= 4; c++) begin
      drive(1, 0, 16'h0050, 8'h0, 1, 1, 0, 16'h0201, 8'h0);
      settle();
      if (c == 0) begin
        total++;
        if (bus.dma_rvalid !== 1'b0) begin
          bad++; $display("FAIL rmb_rvalid got %b want 0", bus.dma_rvalid);
        end
      end
      total++;
      if (bus.dma_gnt !== (c == 4) || bus.cpu_rdy !== (c != 4)) begin
        bad++; $display("FAIL rmb_after cyc=%0d got dma_gnt=%b cpu_rdy=%b want %b %b",
                        c, bus.dma_gnt, bus.cpu_rdy, (c == 4), (c != 4));
      end
      tick();
    end
    idle();
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 16'h0400 + 16'($urandom_range(0, 15)),
            8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
            16'h0400 + 16'($urandom_range(0, 15)), 8'($urandom));
      settle();
      total++;
      if (bus.cpu_rdy !== e_cpu || bus.dma_gnt !== e_dma) begin
        bad++; $display("FAIL rnd_grant n=%0d got cpu=%b dma=%b want %b %b", n, bus.cpu_rdy, bus.dma_gnt, e_cpu, e_dma);
      end
      total++;
      if (bus.mem_we !== e_we || bus.mem_addr !== e_addr || (e_we && bus.mem_din !== e_din)) begin
        bad++; $display("FAIL rnd_mem n=%0d got we=%b addr=%h din=%h want %b %h %h",
                        n, bus.mem_we, bus.mem_addr, bus.mem_din, e_we, e_addr, e_din);
      end
      total++;
      if (bus.cpu_rvalid !== m_cpu_rv || bus.dma_rvalid !== m_dma_rv) begin
        bad++; $display("FAIL rnd_rvalid n=%0d got %b %b want %b %b", n, bus.cpu_rvalid, bus.dma_rvalid, m_cpu_rv, m_dma_rv);
      end
      if (m_cpu_rv || m_dma_rv) begin
        total++;
        if ((m_cpu_rv && bus.cpu_rdata !== m_cpu_rd) || (m_dma_rv && bus.dma_rdata !== m_dma_rd)) begin
          bad++; $display("FAIL rnd_rdata n=%0d got cpu=%h dma=%h want cpu=%h dma=%h",
                          n, bus.cpu_rdata, bus.dma_rdata, m_cpu_rd, m_dma_rd);
        end
      end
      tick();
    end
    r = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_starvation();
    test_locked_burst();
    test_lock_release();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
